// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter: opcode width, FSM state
// encoding and the sixteen decoder function codes.
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  // Opcode n selects decoder output E[n]; the arbiter passes these through untouched.
  localparam logic [OP_W-1:0] OP_0  = 4'd0;
  localparam logic [OP_W-1:0] OP_1  = 4'd1;
  localparam logic [OP_W-1:0] OP_2  = 4'd2;
  localparam logic [OP_W-1:0] OP_3  = 4'd3;
  localparam logic [OP_W-1:0] OP_4  = 4'd4;
  localparam logic [OP_W-1:0] OP_5  = 4'd5;
  localparam logic [OP_W-1:0] OP_6  = 4'd6;
  localparam logic [OP_W-1:0] OP_7  = 4'd7;
  localparam logic [OP_W-1:0] OP_8  = 4'd8;
  localparam logic [OP_W-1:0] OP_9  = 4'd9;
  localparam logic [OP_W-1:0] OP_10 = 4'd10;
  localparam logic [OP_W-1:0] OP_11 = 4'd11;
  localparam logic [OP_W-1:0] OP_12 = 4'd12;
  localparam logic [OP_W-1:0] OP_13 = 4'd13;
  localparam logic [OP_W-1:0] OP_14 = 4'd14;
  localparam logic [OP_W-1:0] OP_15 = 4'd15;

endpackage

// File: rtl/alu_op_arbiter_rr_arb.sv
// rr_arb: round-robin grant for NREQ requesters; the first asserted request
// at or after the pointer wins, wrapping NREQ-1 -> 0.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  always_comb begin
    logic          found;
    logic [IW-1:0] j;
    found = 1'b0;
    j     = '0;
    o_gnt = '0;
    o_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IW'((int'(i_ptr) + k) % NREQ);
      if (!found && i_req[j]) begin
        found    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = j;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/alu_op_arbiter.sv
// alu_op_arbiter: shares one ALU between NREQ requesters (round-robin issue,
// fixed-latency capture, one-cycle response). Optional op_count via ALU_ARB_OPCNT_EN.
module alu_op_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OP_W-1:0] req_op,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  output logic                 alu_en,
  output logic [OP_W-1:0]      alu_sel,
  output logic [DW-1:0]        alu_a,
  output logic [DW-1:0]        alu_b,
  input  logic [DW-1:0]        alu_y,
  input  logic                 alu_cout,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic                 rsp_cout,
  output logic                 busy
`ifdef ALU_ARB_OPCNT_EN
  ,
  output logic [15:0]          op_count
`endif
);

  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WAIT_LD = (ALU_LAT > 1) ? ALU_LAT - 2 : 0;

  if (ALU_LAT < 1 || ALU_LAT > 4) begin : g_bad_lat
    $error("alu_op_arbiter: ALU_LAT must be in 1..4");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("alu_op_arbiter: NREQ must be in 2..8");
  end

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_idx;
  logic [1:0]      r_lat_cnt;
  logic [OP_W-1:0] r_sel;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [DW-1:0]   r_y;
  logic            r_cout;
  logic [NREQ-1:0] r_rsp;

  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic            w_accept;
  logic            w_xfer;
  logic [OP_W-1:0] w_op;
  logic [DW-1:0]   w_a;
  logic [DW-1:0]   w_b;

  rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Grants are offered only in IDLE and never while reset is held.
  assign w_accept  = (r_state == IDLE) && rst_n;
  assign req_ready = w_accept ? w_gnt : '0;
  assign w_xfer    = w_accept && w_any;

  assign w_op = req_op[w_idx*OP_W +: OP_W];
  assign w_a  = req_a[w_idx*DW +: DW];
  assign w_b  = req_b[w_idx*DW +: DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_xfer) w_next = ISSUE;
      ISSUE:   w_next = (ALU_LAT > 1) ? WAIT : CAPTURE;
      WAIT:    if (r_lat_cnt == 2'd0) w_next = CAPTURE;
      CAPTURE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // WAIT lasts ALU_LAT-1 cycles: loaded in ISSUE, counted down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_cnt <= 2'd0;
    end else if (r_state == ISSUE) begin
      r_lat_cnt <= 2'(WAIT_LD);
    end else if (r_state == WAIT && r_lat_cnt != 2'd0) begin
      r_lat_cnt <= r_lat_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_idx <= '0;
      r_sel <= '0;
      r_a   <= '0;
      r_b   <= '0;
    end else if (w_xfer) begin
      r_ptr <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);
      r_idx <= w_idx;
      r_sel <= w_op;
      r_a   <= w_a;
      r_b   <= w_b;
    end
  end

  // Result is sampled in CAPTURE and presented the following cycle, when the FSM is back in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y    <= '0;
      r_cout <= 1'b0;
      r_rsp  <= '0;
    end else if (r_state == CAPTURE) begin
      r_y    <= alu_y;
      r_cout <= alu_cout;
      r_rsp  <= NREQ'(1) << r_idx;
    end else begin
      r_rsp  <= '0;
    end
  end

  assign alu_en    = (r_state == ISSUE);
  assign alu_sel   = r_sel;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign rsp_valid = r_rsp;
  assign rsp_data  = r_y;
  assign rsp_cout  = r_cout;
  assign busy      = (r_state != IDLE);

`ifdef ALU_ARB_OPCNT_EN
  logic [15:0] r_op_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= 16'd0;
    end else if (r_rsp != '0) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Bench for alu_op_arbiter: scoreboarded random traffic on an ALU_LAT=3 instance
// plus a directed single-op sequence on an ALU_LAT=1 instance.
module tb_alu_op_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 4;
  localparam int LAT  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [NREQ-1:0]   req_valid, req_ready, rsp_valid;
  logic [NREQ*4-1:0] req_op;
  logic [NREQ*DW-1:0] req_a, req_b;
  logic alu_en, alu_cout, rsp_cout, busy;
  logic [3:0] alu_sel;
  logic [DW-1:0] alu_a, alu_b, alu_y, rsp_data;

  logic [NREQ-1:0]   d1_valid, d1_ready, d1_rsp;
  logic [NREQ*4-1:0] d1_op;
  logic [NREQ*DW-1:0] d1_a, d1_b;
  logic d1_alu_en, d1_alu_cout, d1_rsp_cout, d1_busy;
  logic [3:0] d1_alu_sel;
  logic [DW-1:0] d1_alu_a, d1_alu_b, d1_alu_y, d1_rsp_data;
`ifdef ALU_ARB_OPCNT_EN
  logic [15:0] op_count, d1_op_count;
`endif

  alu_op_arbiter #(.NREQ(NREQ), .DW(DW), .ALU_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_en(alu_en), .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_cout(rsp_cout), .busy(busy)
`ifdef ALU_ARB_OPCNT_EN
    , .op_count(op_count)
`endif
  );

  alu_op_arbiter #(.NREQ(NREQ), .DW(DW), .ALU_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(d1_valid), .req_ready(d1_ready), .req_op(d1_op), .req_a(d1_a), .req_b(d1_b),
    .alu_en(d1_alu_en), .alu_sel(d1_alu_sel), .alu_a(d1_alu_a), .alu_b(d1_alu_b),
    .alu_y(d1_alu_y), .alu_cout(d1_alu_cout),
    .rsp_valid(d1_rsp), .rsp_data(d1_rsp_data), .rsp_cout(d1_rsp_cout), .busy(d1_busy)
`ifdef ALU_ARB_OPCNT_EN
    , .op_count(d1_op_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural 16-function ALU: {carry, result}.
  function automatic logic [4:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] ea, eb;
    logic [7:0] m;
    ea = {1'b0, a};
    eb = {1'b0, b};
    m  = a * b;
    case (op)
      4'd0:    return ea + eb;
      4'd1:    return ea - eb;
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      4'd5:    return ea + eb + 5'd1;
      4'd6:    return {1'b0, ~a};
      4'd7:    return {a, 1'b0};
      4'd8:    return {a[0], 1'b0, a[3:1]};
      4'd9:    return ea + 5'd1;
      4'd10:   return ea - 5'd1;
      4'd11:   return {1'b0, ~(a & b)};
      4'd12:   return {1'b0, ~(a | b)};
      4'd13:   return {1'b0, b};
      4'd14:   return {1'b0, a};
      default: return {|m[7:4], m[3:0]};
    endcase
  endfunction

  // ALU models: the true result appears only LAT cycles after alu_en, complement otherwise.
  logic       pv [LAT];
  logic [4:0] pr [LAT];
  initial for (int k = 0; k < LAT; k++) begin pv[k] = 1'b0; pr[k] = 5'd0; end
  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) begin
      pv[k] <= pv[k-1];
      pr[k] <= pr[k-1];
    end
    pv[0] <= alu_en;
    pr[0] <= alu_f(alu_sel, alu_a, alu_b);
  end
  assign alu_y    = pv[LAT-1] ? pr[LAT-1][3:0] : ~pr[LAT-1][3:0];
  assign alu_cout = pv[LAT-1] ? pr[LAT-1][4]   : ~pr[LAT-1][4];

  logic d1_pv = 1'b0;
  logic [4:0] d1_r;
  always @(posedge clk) d1_pv <= d1_alu_en;
  assign d1_r        = alu_f(d1_alu_sel, d1_alu_a, d1_alu_b);
  assign d1_alu_y    = d1_pv ? d1_r[3:0] : ~d1_r[3:0];
  assign d1_alu_cout = d1_pv ? d1_r[4]   : ~d1_r[4];

  typedef struct {
    int         idx;
    logic [3:0] y;
    logic       c;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   glog[$];
  int   m_ptr = 0;
  int   m_free = 0;
  int   m_issue = -10;
  int   m_cnt = 0;
  logic [3:0] m_sel, m_a, m_b;
  logic [NREQ-1:0] xfer_vec = '0;

  // Reference arbiter: predicts ready/busy/issue and pushes expected responses.
  always @(negedge clk) begin : push_blk
    logic [NREQ-1:0] exp_rdy;
    int g, j;
    if (!rst_n) begin
      sb.delete();
      m_ptr = 0;
      m_free = 0;
      xfer_vec = '0;
      check("rst_ready", req_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_alu_en", alu_en, 0);
    end else begin
      exp_rdy = '0;
      g = -1;
      if (cyc >= m_free) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (m_ptr + k) % NREQ;
          if (g < 0 && req_valid[j]) g = j;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("ready", req_ready, exp_rdy);
      check("busy", busy, cyc < m_free);
      check("alu_en", alu_en, cyc == m_issue);
      if (cyc >= m_issue && cyc < m_free) begin
        check("alu_sel_hold", alu_sel, m_sel);
        check("alu_a_hold", alu_a, m_a);
        check("alu_b_hold", alu_b, m_b);
      end
      xfer_vec = exp_rdy;
      if (g >= 0) begin
        m_sel = req_op[4*g +: 4];
        m_a   = req_a[DW*g +: DW];
        m_b   = req_b[DW*g +: DW];
        sb.push_back('{idx: g, y: alu_f(m_sel, m_a, m_b) & 5'h0F,
                       c: alu_f(m_sel, m_a, m_b) >> 4, due: cyc + LAT + 2});
        glog.push_back(g);
        m_ptr   = (g + 1) % NREQ;
        m_free  = cyc + LAT + 2;
        m_issue = cyc + 1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever a response pulse appears.
  always @(negedge clk) begin : pop_blk
    exp_t e;
    if (!rst_n) begin
      m_cnt = 0;
      check("rst_rsp_valid", rsp_valid, 0);
    end else begin
`ifdef ALU_ARB_OPCNT_EN
      check("op_count", op_count, 16'(m_cnt));
`endif
      if (rsp_valid != '0) begin
        m_cnt++;
        if (sb.size() == 0) begin
          check("rsp_spurious", rsp_valid, 0);
        end else begin
          e = sb.pop_front();
          check("rsp_valid", rsp_valid, 32'd1 << e.idx);
          check("rsp_data", rsp_data, e.y);
          check("rsp_cout", rsp_cout, e.c);
          check("rsp_cycle", cyc, e.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("rsp_missing", rsp_valid, 32'd1 << e.idx);
      end
    end
  end

  task automatic load(input int i);
    req_valid[i]       = 1'b1;
    req_op[4*i +: 4]   = 4'($urandom);
    req_a[DW*i +: DW]  = DW'($urandom);
    req_b[DW*i +: DW]  = DW'($urandom);
  endtask

  // mode 0: drop after transfer; 1: reload and keep requesting; 2: random traffic
  task automatic step(input int mode);
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (xfer_vec[i]) begin
        if (mode == 1) load(i);
        else req_valid[i] = 1'b0;
      end else if (mode == 2) begin
        if (req_valid[i]) begin
          if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          load(i);
        end
      end
    end
  endtask

  task automatic wait_ready(input int i, output int t);
    t = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        t = cyc;
        return;
      end
    end
    check("grant_timeout", 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_alu_en"}, alu_en, 0);
    check({tag, "_alu_sel"}, alu_sel, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_cout"}, rsp_cout, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [4:0] r;
    rst_n = 1'b0;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    d1_valid = '0; d1_op = '0; d1_a = '0; d1_b = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single op on the ALU_LAT=1 instance
    @(posedge clk); #1;
    d1_valid = 4'b0001; d1_op[3:0] = 4'h5; d1_a[3:0] = 4'd3; d1_b[3:0] = 4'd6;
    @(negedge clk);
    check("d1_ready_T", d1_ready, 4'b0001);
    check("d1_alu_en_T", d1_alu_en, 0);
    @(posedge clk); #1;
    d1_valid = '0;
    @(negedge clk);
    check("d1_alu_en_T1", d1_alu_en, 1);
    check("d1_alu_sel_T1", d1_alu_sel, 4'h5);
    check("d1_alu_a_T1", d1_alu_a, 4'd3);
    check("d1_alu_b_T1", d1_alu_b, 4'd6);
    check("d1_busy_T1", d1_busy, 1);
    @(negedge clk);
    check("d1_alu_en_T2", d1_alu_en, 0);
    check("d1_rsp_T2", d1_rsp, 0);
    @(negedge clk);
    r = alu_f(4'h5, 4'd3, 4'd6);
    check("d1_rsp_T3", d1_rsp, 4'b0001);
    check("d1_data_T3", d1_rsp_data, r[3:0]);
    check("d1_cout_T3", d1_rsp_cout, r[4]);
    check("d1_busy_T3", d1_busy, 0);
    @(negedge clk);
    check("d1_rsp_T4", d1_rsp, 0);

    // Round robin with every requester held high
    step(0);
    glog.delete();
    for (int i = 0; i < NREQ; i++) load(i);
    for (int n = 0; n < 60 && glog.size() < 5; n++) step(1);
    check("rr_count", glog.size() >= 5, 1);
    if (glog.size() >= 5) begin
      check("rr_g0", glog[0], 0);
      check("rr_g1", glog[1], 1);
      check("rr_g2", glog[2], 2);
      check("rr_g3", glog[3], 3);
      check("rr_g4", glog[4], 0);
    end
    req_valid = '0;
    repeat (8) step(0);

    // Opcode F on requester 2: held operands and response at T+5
    load(2);
    req_op[11:8] = 4'hF;
    wait_ready(2, t);
    if (t >= 0) begin
      step(0);
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        check("t4_alu_sel", alu_sel, 4'hF);
      end
      @(negedge clk);
      check("t4_rsp_T5", rsp_valid, 4'b0100);
    end

    // Reset during WAIT drops the pending response and clears the pointer
    step(0);
    load(0);
    wait_ready(0, t);
    step(0);
    load(1);
    load(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t5_rst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("t5_first_grant", req_ready, 4'b0010);
    repeat (12) step(0);

    // Random traffic
    repeat (3000) step(2);
    req_valid = '0;
    repeat (12) step(0);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
